// File: rtl/reset_request_gen_pkg.sv
// Shared definitions for the reset request generator.
//   state_t    : FSM state encoding (IDLE, RUN, ASSERT, HOLDOFF)
//   CAUSE_*    : encodings reported on the cause output
//   CNT_W      : width of the pulse/holdoff counter (parameters are 1..255)
package reset_request_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_ASSERT  = 2'd2,
    ST_HOLDOFF = 2'd3
  } state_t;

  localparam logic [1:0] CAUSE_NONE = 2'b00;
  localparam logic [1:0] CAUSE_SW   = 2'b01;
  localparam logic [1:0] CAUSE_WDOG = 2'b10;

  localparam int CNT_W = 8;

endpackage

// File: rtl/reset_release_sync.sv
// Two-flop reset synchronizer: assertion is asynchronous, deassertion is
// aligned to clk after two edges.
//   clk     : destination clock
//   i_rst_n : raw active-low reset
//   o_rst_n : active-low reset, async assert / sync deassert
module reset_release_sync (
  input  logic clk,
  input  logic i_rst_n,
  output logic o_rst_n
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= 1'b1;
      r_sync <= r_meta;
    end
  end

  assign o_rst_n = r_sync;

endmodule

// File: rtl/reset_request_gen.sv
// Reset request generator: watchdog plus software reset request, producing a
// fixed-width registered reset pulse followed by a quiet holdoff period.
//   clk        : single clock
//   reset      : async active-low reset (release synchronized locally)
//   wdEnable   : arms the watchdog
//   wdKick     : single-cycle pulse, restarts the watchdog count
//   wdTimeout  : watchdog period in cycles, 0 disables the watchdog
//   swResetReq : single-cycle software reset request
//   resetReq   : registered active-high reset request pulse
//   cause      : 00 none, 01 software, 10 watchdog (held until next request)
//   busy       : high while in ASSERT or HOLDOFF
module reset_request_gen
  import reset_request_gen_pkg::*;
#(
  parameter int PULSE_CYCLES   = 16,
  parameter int HOLDOFF_CYCLES = 64,
  parameter int TIMEOUT_WIDTH  = 24
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wdEnable,
  input  logic                     wdKick,
  input  logic [TIMEOUT_WIDTH-1:0] wdTimeout,
  input  logic                     swResetReq,
  output logic                     resetReq,
  output logic [1:0]               cause,
  output logic                     busy
);

  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLDOFF_CYCLES - 1);

  logic                     w_rst_n;
  logic                     w_wd_armed;
  logic [TIMEOUT_WIDTH-1:0] w_last;

  state_t                   r_state;
  logic [TIMEOUT_WIDTH-1:0] r_cnt;
  logic [CNT_W-1:0]         r_pcnt;
  logic                     r_reset_req;
  logic [1:0]               r_cause;
  logic                     r_busy;

  reset_release_sync u_rst_sync (
    .clk     (clk),
    .i_rst_n (reset),
    .o_rst_n (w_rst_n)
  );

  assign w_wd_armed = wdEnable && (wdTimeout != '0);
  // Only used when wdTimeout != 0, so the subtraction never underflows.
  assign w_last     = wdTimeout - 1'b1;

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_pcnt      <= '0;
      r_reset_req <= 1'b0;
      r_cause     <= CAUSE_NONE;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_cnt <= '0;
          if (swResetReq) begin
            r_state     <= ST_ASSERT;
            r_reset_req <= 1'b1;
            r_cause     <= CAUSE_SW;
            r_busy      <= 1'b1;
            r_pcnt      <= '0;
          end else if (w_wd_armed) begin
            r_state <= ST_RUN;
          end
        end

        ST_RUN: begin
          // Software request wins over disable, kick and timeout.
          if (swResetReq) begin
            r_state     <= ST_ASSERT;
            r_reset_req <= 1'b1;
            r_cause     <= CAUSE_SW;
            r_busy      <= 1'b1;
            r_pcnt      <= '0;
            r_cnt       <= '0;
          end else if (!w_wd_armed) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
          end else if (wdKick) begin
            r_cnt <= '0;
          end else if (r_cnt >= w_last) begin
            // >= so a shrinking wdTimeout mid-run fires on the next compare
            r_state     <= ST_ASSERT;
            r_reset_req <= 1'b1;
            r_cause     <= CAUSE_WDOG;
            r_busy      <= 1'b1;
            r_pcnt      <= '0;
            r_cnt       <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        ST_ASSERT: begin
          r_cnt <= '0;
          if (r_pcnt == PULSE_LAST) begin
            r_state     <= ST_HOLDOFF;
            r_reset_req <= 1'b0;
            r_pcnt      <= '0;
          end else begin
            r_pcnt <= r_pcnt + 1'b1;
          end
        end

        ST_HOLDOFF: begin
          r_cnt <= '0;
          if (r_pcnt == HOLD_LAST) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_pcnt  <= '0;
          end else begin
            r_pcnt <= r_pcnt + 1'b1;
          end
        end

        default: begin
          r_state     <= ST_IDLE;
          r_cnt       <= '0;
          r_pcnt      <= '0;
          r_reset_req <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign resetReq = r_reset_req;
  assign cause    = r_cause;
  assign busy     = r_busy;

endmodule

// File: tb/tb_reset_request_gen.sv
module tb_reset_request_gen;
  import reset_request_gen_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        wdEnable = 1'b0;
  logic        wdKick = 1'b0;
  logic [23:0] wdTimeout = '0;
  logic        swResetReq = 1'b0;
  logic        resetReq;
  logic [1:0]  cause;
  logic        busy;

  int checks = 0;
  int failures = 0;

  reset_request_gen #(.PULSE_CYCLES(16), .HOLDOFF_CYCLES(64), .TIMEOUT_WIDTH(24)) dut (
    .clk        (clk),
    .reset      (reset),
    .wdEnable   (wdEnable),
    .wdKick     (wdKick),
    .wdTimeout  (wdTimeout),
    .swResetReq (swResetReq),
    .resetReq   (resetReq),
    .cause      (cause),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Count cycles (from now) until resetReq rises; bounded.
  task automatic cycles_to_rise(output int k);
    k = 0;
    while (!resetReq && k < 2000) begin
      step(1);
      k++;
    end
  endtask

  // Count consecutive cycles resetReq stays high starting now.
  task automatic pulse_width(output int n);
    n = 0;
    while (resetReq && n < 500) begin
      n++;
      step(1);
    end
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    while (busy && k < 500) begin
      step(1);
      k++;
    end
    chk(tag, int'(busy), 0);
  endtask

  initial begin
    int k, n, nb, seen;

    // ---- reset state ----
    step(3);
    chk("rst_resetReq", int'(resetReq), 0);
    chk("rst_cause", int'(cause), int'(CAUSE_NONE));
    chk("rst_busy", int'(busy), 0);
    reset = 1'b1;
    step(4);
    chk("rst_state", int'(dut.r_state), int'(ST_IDLE));
    chk("rst_rel_resetReq", int'(resetReq), 0);

    // ---- software request from IDLE ----
    swResetReq = 1'b1;
    chk("sw_latency_pre", int'(resetReq), 0);
    step(1);
    swResetReq = 1'b0;
    chk("sw_rise", int'(resetReq), 1);
    chk("sw_cause", int'(cause), int'(CAUSE_SW));
    n = 0; nb = 0;
    for (int i = 0; i < 200; i++) begin
      if (resetReq) n++;
      if (busy) nb++;
      step(1);
    end
    chk("sw_pulse_width", n, 16);
    chk("sw_busy_width", nb, 80);
    chk("sw_cause_hold", int'(cause), int'(CAUSE_SW));
    chk("sw_back_idle", int'(dut.r_state), int'(ST_IDLE));

    // ---- watchdog timeout, no kick ----
    wdTimeout = 24'd100;
    wdEnable = 1'b1;
    step(1);                       // edge that enters RUN
    cycles_to_rise(k);
    wdEnable = 1'b0;
    chk("wd_rise_cycles", k, 100);
    chk("wd_cause", int'(cause), int'(CAUSE_WDOG));
    pulse_width(n);
    chk("wd_pulse_width", n, 16);
    wait_idle("wd_idle");

    // ---- kick every 50 cycles for 1000 cycles ----
    wdEnable = 1'b1;
    step(1);
    seen = 0;
    for (int i = 0; i < 1000; i++) begin
      wdKick = (i % 50 == 49);
      step(1);
      if (resetReq) seen++;
    end
    wdKick = 1'b0;
    chk("kick_no_pulse", seen, 0);
    cycles_to_rise(k);
    wdEnable = 1'b0;
    chk("kick_last_to_rise", k, 100);
    chk("kick_cause", int'(cause), int'(CAUSE_WDOG));
    wait_idle("kick_idle");

    // ---- kick on the timeout cycle suppresses it ----
    wdTimeout = 24'd10;
    wdEnable = 1'b1;
    step(1);
    step(9);
    wdKick = 1'b1;
    step(1);
    wdKick = 1'b0;
    chk("kick_on_to_suppress", int'(resetReq), 0);
    cycles_to_rise(k);
    wdEnable = 1'b0;
    chk("kick_on_to_rise", k, 10);
    wait_idle("kick_on_to_idle");

    // ---- wdTimeout lowered mid-RUN: counter already past -> fires next edge ----
    wdTimeout = 24'd100;
    wdEnable = 1'b1;
    step(1);
    step(49);
    chk("shrink_pre", int'(resetReq), 0);
    wdTimeout = 24'd20;
    step(1);
    wdEnable = 1'b0;
    chk("shrink_fire", int'(resetReq), 1);
    chk("shrink_cause", int'(cause), int'(CAUSE_WDOG));
    wait_idle("shrink_idle");

    // ---- collision: sw request on the timeout cycle, then sw in HOLDOFF ----
    wdTimeout = 24'd10;
    wdEnable = 1'b1;
    step(1);
    step(9);
    chk("coll_pre", int'(resetReq), 0);
    swResetReq = 1'b1;
    step(1);
    swResetReq = 1'b0;
    wdEnable = 1'b0;
    chk("coll_rise", int'(resetReq), 1);
    chk("coll_cause", int'(cause), int'(CAUSE_SW));
    step(20);
    chk("coll_in_holdoff", int'(dut.r_state), int'(ST_HOLDOFF));
    swResetReq = 1'b1;
    step(1);
    swResetReq = 1'b0;
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      if (resetReq) seen++;
      step(1);
    end
    chk("holdoff_drop", seen, 0);
    chk("holdoff_busy_done", int'(busy), 0);

    // ---- request during ASSERT is dropped ----
    swResetReq = 1'b1;
    step(1);
    swResetReq = 1'b0;
    step(5);
    swResetReq = 1'b1;
    step(1);
    swResetReq = 1'b0;
    nb = 0;
    for (int i = 0; i < 200; i++) begin
      if (busy) nb++;
      step(1);
    end
    chk("assert_drop_busy", nb, 80 - 6);

    // ---- reset mid-pulse ----
    swResetReq = 1'b1;
    step(1);
    swResetReq = 1'b0;
    step(4);                       // pulse cycle 5
    chk("midrst_pre", int'(resetReq), 1);
    reset = 1'b0;
    #1;
    chk("midrst_async_drop", int'(resetReq), 0);
    chk("midrst_cause", int'(cause), int'(CAUSE_NONE));
    chk("midrst_busy", int'(busy), 0);
    step(2);
    reset = 1'b1;
    step(4);
    chk("midrst_state", int'(dut.r_state), int'(ST_IDLE));
    chk("midrst_rel_resetReq", int'(resetReq), 0);

    // ---- watchdog disabled by wdTimeout=0 ----
    wdTimeout = '0;
    wdEnable = 1'b1;
    seen = 0;
    for (int i = 0; i < 3000; i++) begin
      step(1);
      if (resetReq || dut.r_state != ST_IDLE) seen++;
    end
    wdEnable = 1'b0;
    chk("disabled_stays_idle", seen, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
